toggle_event_rx: RTL
====================

# toggle_event_rx

Receive side of the toggle-encoded button/event line. It recovers discrete events from a level that flips once per event, such as the output of the press-toggle debouncer. The incoming level is asynchronous: it may cross a clock domain or come off a pin. The block synchronises it, optionally glitch-filters it, and queues each flip as one event in a saturating pending counter. A valid/ready handshake drains the counter, and overflow is flagged.

## Interface
- SYNC_STAGES, 2: synchroniser flops on toggle_in; minimum 2.
- PENDING_WIDTH, 4: width of pending-event counter; maximum queued events = 2^PENDING_WIDTH-1.
- FILTER_CYCLES, 16: consecutive cycles a new level must hold before acceptance; used only with the filter macro; minimum 1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- toggle_in  in  1  asynchronous toggle-encoded event line.
- event_valid  out  1  at least one event pending.
- event_ready  in  1  consumer accepts one event when high with event_valid.
- pending  out  PENDING_WIDTH  number of queued events.
- level  out  1  currently accepted toggle level.
- overflow  out  1  sticky: an event was dropped because pending was saturated.
- clear_overflow  in  1  synchronous clear of overflow.

## Operation
- Reset values:
  - all synchroniser stages 0.
  - level 0.
  - pending 0.
  - overflow 0.
  - filter counter 0.
- event_valid is defined as (pending != 0), decoded from the pending register. It has no extra state.
- Event detection (filter compiled out): on any cycle where the synchronised input differs from level, level takes the synchronised value at the next edge and one event is generated.
- A toggle_in high at reset release is therefore counted as one event. This is deliberate: transmitter and receiver must be reset together.
- Pending counter, per cycle, with inc = event generated and dec = event_valid & event_ready:
  - inc only, pending < max: pending+1.
  - inc only, pending == max: hold, set overflow.
  - dec only: pending-1.
  - inc and dec: hold. No overflow, even at max, because a slot is freed.
  - neither: hold.
- Decrement never occurs at pending == 0, because event_valid is low then.
- event_ready while event_valid is low is ignored.
- overflow is cleared by clear_overflow. If a new overflow occurs in the same cycle as the clear, the set wins.
- Two toggle_in flips in consecutive cycles are not guaranteed to be seen. The transmitter must hold each level for at least SYNC_STAGES+1 cycles, plus FILTER_CYCLES when the filter is compiled in.
- Reset mid-operation clears all pending events immediately; nothing is replayed.

## Timing
- Let edge E be the first clk edge that samples the new toggle_in level.
- Without the filter:
  - the synchronised value changes at E+SYNC_STAGES-1.
  - level, pending and event_valid update at E+SYNC_STAGES.
  - Total latency from input change to event_valid: SYNC_STAGES+1 edges, counting E.
- Handshake: a transfer occurs on an edge where event_valid & event_ready. pending reflects it after that edge. Back-to-back transfers every cycle are supported.
- With the filter: add FILTER_CYCLES-1 cycles to the latency.
- overflow asserts on the same edge that the dropped event would have incremented pending.

## Configuration
- Macro: TOGGLE_EVENT_RX_FILTER_EN.
- Defined:
  - A filter counter of width $clog2(FILTER_CYCLES+1) counts consecutive cycles in which the synchronised input differs from level.
  - The counter resets to 0 on any cycle where they are equal.
  - When the counter reaches FILTER_CYCLES-1 and the mismatch persists, level flips, one event is generated, and the counter clears.
  - Excursions shorter than FILTER_CYCLES produce no event and leave level unchanged.
- Undefined: no filter counter is built; FILTER_CYCLES is ignored; behaviour is exactly as in Operation.

## Structure
- Shared package toggle_event_pkg holds:
  - default parameter constants (SYNC_STAGES, PENDING_WIDTH, FILTER_CYCLES).
  - the minimum-hold-time formula, used by the transmitter-side checks and by the bench.
- One sub-module: sync_chain.
  - Parameterised SYNC_STAGES-deep flop chain with asynchronous reset to 0.
  - Reused by other asynchronous inputs in the design.
- Detection, filter, pending counter and overflow logic live in toggle_event_rx.

## Test plan
- Single event: reset, toggle_in 0→1, event_ready=0. Required: event_valid high after SYNC_STAGES+1 edges (3 with defaults), pending=1, level=1.
- Drain: queue 3 events with ready low, then ready=1. Required: pending 3→2→1→0 on consecutive edges, then event_valid low.
- Saturation: 16 flips with ready low (PENDING_WIDTH=4). Required: pending holds at 15 and overflow=1. clear_overflow then gives overflow=0. A flip coincident with clear_overflow at pending 15 leaves overflow=1.
- Simultaneous inc/dec: at pending=15, flip toggle_in and hold ready high so both land on one edge. Required: pending stays 15 and overflow stays 0.
- Filter defined, FILTER_CYCLES=16:
  - 10-cycle high glitch: no event, level stays 0.
  - 16-cycle hold: exactly one event, latency SYNC_STAGES+FILTER_CYCLES.
- Reset mid-operation: pending=5, assert rst for 1 cycle. Required: all outputs at reset values immediately. With toggle_in high at release, exactly one event after SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/toggle_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_pkg
// Description : Shared defaults and minimum-hold-time helper for the toggle
//               event line (transmitter checks and receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package toggle_event_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_PENDING_WIDTH = 4;
    localparam int DEFAULT_FILTER_CYCLES = 16;

    // Cycles a transmitter must hold each level so the receiver is guaranteed to see it.
    function automatic int min_hold_cycles(input int sync_stages,
                                           input int filter_cycles,
                                           input bit filter_en);
        return sync_stages + 1 + (filter_en ? filter_cycles : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_event_rx_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : SYNC_STAGES-deep flop synchroniser, asynchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/toggle_event_rx.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_rx
// Description : Recovers discrete events from a toggle-encoded level and
//               queues them in a saturating pending counter drained by
//               valid/ready. Optional glitch filter: TOGGLE_EVENT_RX_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_event_rx
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int PENDING_WIDTH = DEFAULT_PENDING_WIDTH,
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     toggle_in,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic                     level,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam logic [PENDING_WIDTH-1:0] c_PEND_MAX = '1;

    logic w_sync;
    logic w_inc;
    logic w_dec;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (toggle_in),
        .o_q (w_sync)
    );

`ifdef TOGGLE_EVENT_RX_FILTER_EN
    localparam int              c_FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_CYCLES - 1);

    logic [c_FW-1:0] r_filt_cnt;

    // The new level is accepted on the FILTER_CYCLES-th consecutive mismatch.
    assign w_inc = (w_sync != level) && (r_filt_cnt == c_FILT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_cnt <= '0;
        end else if ((w_sync == level) || w_inc) begin
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end
`else
    // FILTER_CYCLES has no effect when the filter is not built.
    logic w_unused_cfg;
    assign w_unused_cfg = (FILTER_CYCLES > 0);

    assign w_inc = (w_sync != level);
`endif

    assign event_valid = (pending != '0);
    assign w_dec       = event_valid & event_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
        end else if (w_inc) begin
            level <= ~level;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            case ({w_inc, w_dec})
                2'b10: begin
                    if (pending == c_PEND_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        pending  <= pending + 1'b1;
                        overflow <= overflow & ~clear_overflow;
                    end
                end
                2'b01: begin
                    pending  <= pending - 1'b1;
                    overflow <= overflow & ~clear_overflow;
                end
                default: begin
                    // Simultaneous inc/dec frees a slot, so it never overflows.
                    overflow <= overflow & ~clear_overflow;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
